// File: rtl/rv_prog_loader.sv
// Byte-stream program loader: assembles little-endian words, mirrors them into im/dm,
// and holds the core in reset until the image is in. Optional checksum: LOADER_CHECKSUM_EN.
module rv_prog_loader #(
    parameter int          ADDR_WIDTH = 14,
    parameter int unsigned MEM_WORDS  = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t                  state_q;
    logic [1:0]              byteIdx_q;
    logic [23:0]             word_q;
    logic [15:0]             count_q;
    logic                    memWe_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic [31:0]             memWdata_q;
    logic                    cpuRst_q;
    logic                    done_q;
    logic                    err_q;
    logic [15:0]             words_q;
    logic [15:0]             hdrCount_d;
    logic                    accepting;
    logic                    accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_q;
`endif

    always_comb begin
        accepting = 1'b0;
        case (state_q)
            HDR0, HDR1, DATA: accepting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CSUM:             accepting = 1'b1;
`endif
            default:          accepting = 1'b0;
        endcase
    end

    assign in_ready   = accepting & ~rst;
    assign accept     = in_valid & in_ready;
    assign hdrCount_d = {in_data, count_q[7:0]};

    // The write pulse lands together with the state change into DONE, so the
    // core release is deferred by one more cycle inside DONE itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HDR0;
            byteIdx_q  <= 2'd0;
            word_q     <= '0;
            count_q    <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuRst_q   <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            memWe_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (accept && (state_q == HDR0 || state_q == HDR1 || state_q == DATA))
                csum_q <= csum_q ^ in_data;
`endif
            case (state_q)
                HDR0: begin
                    if (accept) begin
                        count_q[7:0] <= in_data;
                        state_q      <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        count_q[15:8] <= in_data;
                        if ({16'd0, hdrCount_d} > MEM_WORDS) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else if (hdrCount_d == 16'd0) begin
                            state_q <= AFTER_DATA;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        case (byteIdx_q)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                memWe_q    <= 1'b1;
                                memAddr_q  <= words_q[ADDR_WIDTH-1:0];
                                memWdata_q <= {in_data, word_q};
                                if (words_q != 16'hFFFF)
                                    words_q <= words_q + 16'd1;
                                if (words_q == count_q - 16'd1)
                                    state_q <= AFTER_DATA;
                            end
                        endcase
                        byteIdx_q <= byteIdx_q + 2'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (in_data == csum_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    cpuRst_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we       = memWe_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign cpu_rst      = cpuRst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_rv_prog_loader.sv
// Directed bench for rv_prog_loader: table of whole-stream vectors plus hand-written
// sequences for release timing, oversize header and mid-load reset.
module tb_rv_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [13:0] logAddr[64];
    logic [31:0] logData[64];
    int          logCount = 0;

    rv_prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Every write pulse is captured once, mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            logAddr[logCount % 64] = mem_addr;
            logData[logCount % 64] = mem_wdata;
            logCount = logCount + 1;
        end
    end

    typedef struct {
        string       name;
        int          len;
        logic [95:0] stream;
        int          gap;
        int          expWrites;
        logic [13:0] a0;
        logic [31:0] d0;
        logic [13:0] a1;
        logic [31:0] d1;
        logic        expDone;
        logic        expErr;
        logic [15:0] expWords;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [95:0] lj(input logic [95:0] v, input int len);
        return v << (8 * (12 - len));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        checkOutput("in_ready during rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst mem_addr", {18'd0, mem_addr}, 32'd0);
        checkOutput("rst mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst err", {31'd0, err}, 32'd0);
        checkOutput("rst words_loaded", {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte accept timeout: in_ready=%0d, expected 1", in_ready);
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [95:0] stream, input int len, input int gap);
        for (int i = 0; i < len; i++)
            sendByte(stream[95 - 8 * i -: 8], gap);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

`ifndef LOADER_CHECKSUM_EN
        vecs.push_back('{"two words", 10, lj(96'h0200_1300_0000_B301_0000, 10), 0,
                         2, 14'd0, 32'h0000_0013, 14'd1, 32'h0000_01B3, 1'b1, 1'b0, 16'd2});
        vecs.push_back('{"two words gapped", 10, lj(96'h0200_1300_0000_B301_0000, 10), 1,
                         2, 14'd0, 32'h0000_0013, 14'd1, 32'h0000_01B3, 1'b1, 1'b0, 16'd2});
        vecs.push_back('{"empty image", 2, lj(96'h0000, 2), 0,
                         0, 14'd0, 32'd0, 14'd0, 32'd0, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{"one word", 6, lj(96'h0100_7856_3412, 6), 2,
                         1, 14'd0, 32'h1234_5678, 14'd0, 32'd0, 1'b1, 1'b0, 16'd1});
`else
        vecs.push_back('{"two words csum", 11, lj(96'h0200_1300_0000_B301_0000_A3, 11), 0,
                         2, 14'd0, 32'h0000_0013, 14'd1, 32'h0000_01B3, 1'b1, 1'b0, 16'd2});
        vecs.push_back('{"two words gapped csum", 11, lj(96'h0200_1300_0000_B301_0000_A3, 11), 1,
                         2, 14'd0, 32'h0000_0013, 14'd1, 32'h0000_01B3, 1'b1, 1'b0, 16'd2});
        vecs.push_back('{"empty image csum", 3, lj(96'h00_0000, 3), 0,
                         0, 14'd0, 32'd0, 14'd0, 32'd0, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{"csum good", 7, lj(96'h0100_0102_0304_05, 7), 0,
                         1, 14'd0, 32'h0403_0201, 14'd0, 32'd0, 1'b1, 1'b0, 16'd1});
        vecs.push_back('{"csum bad", 7, lj(96'h0100_0102_0304_06, 7), 0,
                         1, 14'd0, 32'h0403_0201, 14'd0, 32'd0, 1'b0, 1'b1, 16'd1});
`endif

        foreach (vecs[v]) begin
            doReset();
            base = logCount;
            applyStimulus(vecs[v].stream, vecs[v].len, vecs[v].gap);
            repeat (3) @(negedge clk);
            #1;
            checkOutput({vecs[v].name, " writes"}, logCount - base, vecs[v].expWrites);
            if (vecs[v].expWrites >= 1) begin
                checkOutput({vecs[v].name, " addr0"}, {18'd0, logAddr[base % 64]}, {18'd0, vecs[v].a0});
                checkOutput({vecs[v].name, " data0"}, logData[base % 64], vecs[v].d0);
            end
            if (vecs[v].expWrites >= 2) begin
                checkOutput({vecs[v].name, " addr1"}, {18'd0, logAddr[(base + 1) % 64]}, {18'd0, vecs[v].a1});
                checkOutput({vecs[v].name, " data1"}, logData[(base + 1) % 64], vecs[v].d1);
            end
            checkOutput({vecs[v].name, " done"}, {31'd0, done}, {31'd0, vecs[v].expDone});
            checkOutput({vecs[v].name, " err"}, {31'd0, err}, {31'd0, vecs[v].expErr});
            checkOutput({vecs[v].name, " cpu_rst"}, {31'd0, cpu_rst}, {31'd0, ~vecs[v].expDone});
            checkOutput({vecs[v].name, " words_loaded"}, {16'd0, words_loaded}, {16'd0, vecs[v].expWords});
            checkOutput({vecs[v].name, " in_ready"}, {31'd0, in_ready}, 32'd0);
        end

        // Release timing: write pulse with the last byte's edge, core released one cycle later.
        doReset();
        applyStimulus(lj(96'h0200_1300_0000_B301_0000, 10), 10, 0);
`ifdef LOADER_CHECKSUM_EN
        sendByte(8'hA3, 0);
`else
        #1;
        checkOutput("timing last mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("timing last addr", {18'd0, mem_addr}, 32'd1);
`endif
        #1;
        checkOutput("timing cpu_rst held", {31'd0, cpu_rst}, 32'd1);
        checkOutput("timing done early", {31'd0, done}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("timing cpu_rst released", {31'd0, cpu_rst}, 32'd0);
        checkOutput("timing done", {31'd0, done}, 32'd1);

        // Oversize header: MEM_WORDS+1 words.
        doReset();
        base = logCount;
        applyStimulus(lj(96'h0140, 2), 2, 0);
        #1;
        checkOutput("oversize err", {31'd0, err}, 32'd1);
        checkOutput("oversize in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 8'h30);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("oversize writes", logCount - base, 0);
        checkOutput("oversize err held", {31'd0, err}, 32'd1);
        checkOutput("oversize cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("oversize in_ready held", {31'd0, in_ready}, 32'd0);
        checkOutput("oversize done", {31'd0, done}, 32'd0);

        // Reset mid-load: the partial second word must never reach memory.
        doReset();
        applyStimulus(lj(96'h0200_1122_3344_55, 7), 7, 0);
        doReset();
        base = logCount;
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(lj(96'h0100_AABB_CCDD_01, 7), 7, 0);
`else
        applyStimulus(lj(96'h0100_AABB_CCDD, 6), 6, 0);
`endif
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reload writes", logCount - base, 1);
        checkOutput("reload addr", {18'd0, logAddr[base % 64]}, 32'd0);
        checkOutput("reload data", logData[base % 64], 32'hDDCC_BBAA);
        checkOutput("reload words_loaded", {16'd0, words_loaded}, 32'd1);
        checkOutput("reload done", {31'd0, done}, 32'd1);
        checkOutput("reload cpu_rst", {31'd0, cpu_rst}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
